// File: rtl/euler_step_sequencer_if.sv
// Handshake and data bundle between the Euler step controller and its requester/datapath.
interface euler_step_sequencer_if #(
   parameter int CNT_W = 16,
   parameter int T_W   = 32
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] num_steps;
   logic [T_W-1:0]   h;
   logic [T_W-1:0]   t0;
   logic             step_done;
   logic             step_start;
   logic             busy;
   logic             final_done;
   logic [T_W-1:0]   t_cur;
   logic [CNT_W-1:0] step_idx;

   modport master (
      output start, abort, num_steps, h, t0, step_done,
      input  step_start, busy, final_done, t_cur, step_idx
   );

   modport slave (
      input  start, abort, num_steps, h, t0, step_done,
      output step_start, busy, final_done, t_cur, step_idx
   );
endinterface

// File: rtl/euler_step_sequencer.sv
// Step controller for the Euler solver: runs num_steps iterations of issue/wait/update,
// advancing time by h per step, then pulses final_done. All outputs are flops.
module euler_step_sequencer #(
   parameter int CNT_W = 16,
   parameter int T_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst_async,
   input  logic                  rst_sync,
   euler_step_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_UPDATE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [T_W-1:0]   T_ZERO   = {T_W{1'b0}};

   state_t           state_r;
   logic [CNT_W-1:0] num_steps_r;
   logic [T_W-1:0]   h_r;
   logic [T_W-1:0]   t_cur_r;
   logic [CNT_W-1:0] step_idx_r;
   logic             step_start_r;
   logic             busy_r;
   logic             final_done_r;
   logic [CNT_W-1:0] step_idx_inc_s;

   // step_idx never reaches num_steps before UPDATE, so this add cannot wrap within a run
   assign step_idx_inc_s = step_idx_r + CNT_ONE;

   // Sequencer FSM; output pulses are set on the transition into ISSUE/DONE so they align with the state
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_r      <= S_IDLE;
         num_steps_r  <= CNT_ZERO;
         h_r          <= T_ZERO;
         t_cur_r      <= T_ZERO;
         step_idx_r   <= CNT_ZERO;
         step_start_r <= 1'b0;
         busy_r       <= 1'b0;
         final_done_r <= 1'b0;
      end else if (rst_sync) begin
         state_r      <= S_IDLE;
         num_steps_r  <= CNT_ZERO;
         h_r          <= T_ZERO;
         t_cur_r      <= T_ZERO;
         step_idx_r   <= CNT_ZERO;
         step_start_r <= 1'b0;
         busy_r       <= 1'b0;
         final_done_r <= 1'b0;
      end else if (bus.abort && (state_r != S_IDLE)) begin
         state_r      <= S_IDLE;
         step_start_r <= 1'b0;
         busy_r       <= 1'b0;
         final_done_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               final_done_r <= 1'b0;
               // an abort in IDLE swallows a simultaneous start
               if (bus.start && !bus.abort) begin
                  num_steps_r <= bus.num_steps;
                  h_r         <= bus.h;
                  t_cur_r     <= bus.t0;
                  step_idx_r  <= CNT_ZERO;
                  busy_r      <= 1'b1;
                  if (bus.num_steps == CNT_ZERO) begin
                     state_r      <= S_DONE;
                     step_start_r <= 1'b0;
                     final_done_r <= 1'b1;
                  end else begin
                     state_r      <= S_ISSUE;
                     step_start_r <= 1'b1;
                  end
               end else begin
                  busy_r       <= 1'b0;
                  step_start_r <= 1'b0;
               end
            end
            S_ISSUE: begin
               step_start_r <= 1'b0;
               state_r      <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.step_done) begin
                  state_r <= S_UPDATE;
               end else begin
                  state_r <= S_WAIT;
               end
            end
            S_UPDATE: begin
               t_cur_r    <= t_cur_r + h_r;
               step_idx_r <= step_idx_inc_s;
               if (step_idx_inc_s == num_steps_r) begin
                  state_r      <= S_DONE;
                  final_done_r <= 1'b1;
               end else begin
                  state_r      <= S_ISSUE;
                  step_start_r <= 1'b1;
               end
            end
            S_DONE: begin
               final_done_r <= 1'b0;
               busy_r       <= 1'b0;
               state_r      <= S_IDLE;
            end
            default: begin
               state_r      <= S_IDLE;
               step_start_r <= 1'b0;
               busy_r       <= 1'b0;
               final_done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.step_start = step_start_r;
   assign bus.busy       = busy_r;
   assign bus.final_done = final_done_r;
   assign bus.t_cur      = t_cur_r;
   assign bus.step_idx   = step_idx_r;
endmodule
